pc_control_unit: RTL and testbench
==================================

// Module: pc_control_unit
// PURPOSE
//  Parametrised program-counter unit with run/halt control. Replaces clock-gated
//  halting with a clock-enable FSM, so clk is never gated. Adds stall, branch
//  redirect, sticky internal halt with resume, target alignment and run counter.
//  Sits between the branch/decode logic and the instruction-memory address port.
// PARAMETERS
//  WIDTH        32            PC width in bits
//  RESET_VECTOR 0             PC value loaded on reset
//  ALIGN_BITS   2             instruction = 2**ALIGN_BITS bytes; PC step = 1<<ALIGN_BITS
//  CNT_W        32            width of run_cycles counter
// PORTS
//  clk            in   1          single clock; all state changes on posedge
//  reset          in   1          synchronous, active-high
//  haltext        in   1          external halt, level-sensitive
//  halt           in   1          internal halt (halt instruction), one-cycle pulse
//  resume         in   1          one-cycle pulse; leaves internal-halt state
//  stall          in   1          hold PC this cycle (pipeline stall)
//  branch_taken   in   1          redirect PC to branch_target this cycle
//  branch_target  in   WIDTH      redirect address
//  PCin           out  WIDTH      current PC (registered)
//  pc_plus        out  WIDTH      PCin + (1<<ALIGN_BITS), combinational, wraps
//  halted         out  1          1 when state != RUN (registered)
//  misalign       out  1          1-cycle pulse: accepted target had low bits set
//  run_cycles     out  CNT_W      cycles in which the PC was enabled
// BEHAVIOUR
//  Reset (sync): PCin=RESET_VECTOR, state=RUN, halted=0, misalign=0,
//    run_cycles=0. Reset overrides every other input in that cycle.
//  FSM states: RUN, HALT_INT, HALT_EXT.
//   RUN:      halt=1 -> HALT_INT; else haltext=1 -> HALT_EXT; else stay.
//   HALT_INT: leave only on resume=1 && haltext=0 -> RUN; halt pulses ignored.
//   HALT_EXT: haltext=0 -> RUN, unless halt=1 that cycle -> HALT_INT.
//  PC enable pc_en = (state==RUN) & ~halt & ~haltext. Haltext/halt freeze the
//    PC in the cycle they are asserted, with no extra cycle of latency.
//  PC update at posedge, highest priority first:
//    reset > ~pc_en (hold) > stall (hold) > branch_taken (load target) > +step.
//  Branch with stall, halt or haltext in the same cycle is dropped.
//    The branch source must re-present the branch.
//  Branch load: PCin <= {branch_target[WIDTH-1:ALIGN_BITS], ALIGN_BITS'b0}.
//    misalign <= |branch_target[ALIGN_BITS-1:0] for that cycle only.
//    misalign=0 in every cycle without an accepted branch.
//  Increment: modulo 2**WIDTH; the all-ones-aligned PC wraps to 0, no flag.
//  Resume latency: resume at edge N -> halted=0 after N. PC advances at N+1.
//    No PC change occurs at edge N.
//  halted is registered: it rises the edge after halt/haltext is sampled.
//    PC is already frozen combinationally in that cycle.
//  run_cycles: +1 on each edge where pc_en=1, stall cycles included.
//    Saturates at all-ones; it does not wrap.
//  Simultaneous halt & resume in RUN: halt wins -> HALT_INT.
//  Reset mid-halt: returns to RUN at RESET_VECTOR, counter cleared.
//  No combinational path from any input to PCin, halted or run_cycles.
// TESTING
//  1 Reset, 4 free cycles, RESET_VECTOR=0 -> PCin 0,4,8,12,16; run_cycles=4.
//  2 branch_taken, target=0x103 -> PCin=0x100, misalign pulses 1 cycle.
//    Same with stall=1 -> PCin held, misalign=0.
//  3 halt pulse at PC=0x20 -> PCin stays 0x20, halted=1 next cycle.
//    Resume 10 cycles later -> halted=0; next PCin 0x24; run_cycles unchanged during halt.
//  4 In HALT_INT, haltext=1 with resume -> still halted.
//    Drop haltext, then resume -> RUN.
//  5 WIDTH=8, PC=0xFC, one step -> PCin=0x00.
//    run_cycles with CNT_W=3 after 10 enabled cycles -> stays 7.
//  6 Reset asserted while in HALT_EXT with haltext=1 -> PCin=RESET_VECTOR.
//    Then immediately HALT_EXT again; halted=1 the following cycle.

Source files
------------

// File: rtl/pc_control_unit.sv
// Program counter with clock-enable run/halt FSM (clk is never gated), stall,
// branch redirect with target alignment, sticky internal halt and saturating run counter.
module pc_control_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       ALIGN_BITS   = 2,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             haltext,
  input  logic             halt,
  input  logic             resume,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] PCin,
  output logic [WIDTH-1:0] pc_plus,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] run_cycles
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(1) << ALIGN_BITS;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP - WIDTH'(1));

  typedef enum logic [1:0] {RUN, HALT_INT, HALT_EXT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt)         state_d = HALT_INT;
        else if (haltext) state_d = HALT_EXT;
      end
      HALT_INT: begin
        if (resume && !haltext) state_d = RUN;
      end
      HALT_EXT: begin
        if (!haltext) state_d = halt ? HALT_INT : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // halt/haltext gate the PC in the same cycle; the state register only lags for `halted`
  assign pc_en   = (state_q == RUN) && !halt && !haltext;
  assign pc_plus = pc_q + STEP;

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    cnt_d = cnt_q;
    if (pc_en) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (!stall) begin
        if (branch_taken) begin
          pc_d  = branch_target & ALIGN_MASK;
          mis_d = |(branch_target & ~ALIGN_MASK);
        end else begin
          pc_d = pc_plus;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCin       = pc_q;
  assign halted     = (state_q != RUN);
  assign misalign   = mis_q;
  assign run_cycles = cnt_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: directed scenarios plus randomized run against a reference model.
module tb_pc_control_unit;

  logic        clk = 1'b0;
  logic        reset, haltext, halt, resume, stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] PCin, pc_plus, run_cycles;
  logic        halted, misalign;

  logic        s_reset;
  logic [7:0]  s_pc, s_pc_plus;
  logic        s_halted, s_mis;
  logic [2:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc, m_cnt;
  logic        m_mis;
  int          m_mode; // 0 running, 1 halted by instruction, 2 halted externally

  always #5 clk = ~clk;

  pc_control_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .haltext(haltext), .halt(halt), .resume(resume),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .PCin(PCin), .pc_plus(pc_plus), .halted(halted), .misalign(misalign),
    .run_cycles(run_cycles)
  );

  pc_control_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .ALIGN_BITS(2), .CNT_W(3)) dut_small (
    .clk(clk), .reset(s_reset), .haltext(1'b0), .halt(1'b0), .resume(1'b0),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(8'h00),
    .PCin(s_pc), .pc_plus(s_pc_plus), .halted(s_halted), .misalign(s_mis),
    .run_cycles(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    bit en;
    if (reset) begin
      m_pc = 32'h0; m_mode = 0; m_mis = 1'b0; m_cnt = 0;
    end else begin
      en    = (m_mode == 0) && !halt && !haltext;
      m_mis = 1'b0;
      if (en) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!stall) begin
          if (branch_taken) begin
            m_pc  = (branch_target / 4) * 4;
            m_mis = (branch_target % 4) != 0;
          end else begin
            m_pc = m_pc + 4;
          end
        end
      end
      if (m_mode == 0) begin
        if (halt) m_mode = 1;
        else if (haltext) m_mode = 2;
      end else if (m_mode == 1) begin
        if (resume && !haltext) m_mode = 0;
      end else begin
        if (!haltext) m_mode = halt ? 1 : 0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (PCin !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", PCin, 32'h0); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    checks++; if (run_cycles !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", run_cycles); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (PCin !== 32'(i * 4)) begin errors++; $display("FAIL free_pc got=%h exp=%h", PCin, 32'(i * 4)); end
    end
    checks++; if (run_cycles !== 32'd4) begin errors++; $display("FAIL free_cnt got=%0d exp=4", run_cycles); end
    checks++; if (pc_plus !== 32'd20) begin errors++; $display("FAIL pc_plus got=%h exp=%h", pc_plus, 32'd20); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    checks++; if (PCin !== 32'h100) begin errors++; $display("FAIL branch_pc got=%h exp=%h", PCin, 32'h100); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL branch_mis got=%b exp=1", misalign); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", misalign); end
    checks++; if (PCin !== 32'h104) begin errors++; $display("FAIL after_branch_pc got=%h exp=%h", PCin, 32'h104); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h203;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    checks++; if (PCin !== 32'h104) begin errors++; $display("FAIL stall_branch_pc got=%h exp=%h", PCin, 32'h104); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL stall_branch_mis got=%b exp=0", misalign); end
  endtask

  task automatic test_halt_resume();
    logic [31:0] c0;
    branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    branch_taken = 1'b0;
    checks++; if (PCin !== 32'h20) begin errors++; $display("FAIL goto20_pc got=%h exp=%h", PCin, 32'h20); end
    c0 = run_cycles;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
    checks++; if (PCin !== 32'h20) begin errors++; $display("FAIL halt_pc got=%h exp=%h", PCin, 32'h20); end
    repeat (10) tick();
    checks++; if (PCin !== 32'h20) begin errors++; $display("FAIL halted_pc got=%h exp=%h", PCin, 32'h20); end
    checks++; if (run_cycles !== c0) begin errors++; $display("FAIL halted_cnt got=%0d exp=%0d", run_cycles, c0); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_flag got=%b exp=0", halted); end
    checks++; if (PCin !== 32'h20) begin errors++; $display("FAIL resume_edge_pc got=%h exp=%h", PCin, 32'h20); end
    tick();
    checks++; if (PCin !== 32'h24) begin errors++; $display("FAIL resume_next_pc got=%h exp=%h", PCin, 32'h24); end
    checks++; if (run_cycles !== c0 + 1) begin errors++; $display("FAIL resume_cnt got=%0d exp=%0d", run_cycles, c0 + 1); end
  endtask

  task automatic test_haltint_haltext();
    logic [31:0] p;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hi_enter got=%b exp=1", halted); end
    haltext = 1'b1; resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hi_resume_blocked got=%b exp=1", halted); end
    haltext = 1'b0;
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hi_sticky got=%b exp=1", halted); end
    p = PCin;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hi_resume got=%b exp=0", halted); end
    tick();
    checks++; if (PCin !== p + 32'd4) begin errors++; $display("FAIL hi_run_pc got=%h exp=%h", PCin, p + 32'd4); end
  endtask

  task automatic test_reset_mid_halt();
    haltext = 1'b1;
    tick(); tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL he_enter got=%b exp=1", halted); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (PCin !== 32'h0) begin errors++; $display("FAIL he_reset_pc got=%h exp=0", PCin); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL he_reset_halted got=%b exp=0", halted); end
    checks++; if (run_cycles !== 32'h0) begin errors++; $display("FAIL he_reset_cnt got=%0d exp=0", run_cycles); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL he_again got=%b exp=1", halted); end
    checks++; if (PCin !== 32'h0) begin errors++; $display("FAIL he_again_pc got=%h exp=0", PCin); end
    haltext = 1'b0;
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL he_leave got=%b exp=0", halted); end
  endtask

  task automatic test_small_wrap_sat();
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    repeat (63) tick();
    checks++; if (s_pc !== 8'hFC) begin errors++; $display("FAIL small_pc got=%h exp=fc", s_pc); end
    checks++; if (s_cnt !== 3'd7) begin errors++; $display("FAIL small_sat got=%0d exp=7", s_cnt); end
    tick();
    checks++; if (s_pc !== 8'h00) begin errors++; $display("FAIL small_wrap got=%h exp=00", s_pc); end
    checks++; if (s_cnt !== 3'd7) begin errors++; $display("FAIL small_sat2 got=%0d exp=7", s_cnt); end
  endtask

  task automatic test_random();
    reset = 1'b1;
    model_step();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      reset         = ($urandom_range(0, 59) == 0);
      halt          = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) haltext = ~haltext;
      resume        = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      model_step();
      tick();
      checks++; if (PCin !== m_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, PCin, m_pc); end
      checks++; if (pc_plus !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus cyc=%0d got=%h exp=%h", i, pc_plus, m_pc + 32'd4); end
      checks++; if (halted !== (m_mode != 0)) begin errors++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", i, halted, m_mode != 0); end
      checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", i, misalign, m_mis); end
      checks++; if (run_cycles !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, run_cycles, m_cnt); end
    end
    reset = 1'b0; halt = 1'b0; haltext = 1'b0; resume = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; haltext = 1'b0; halt = 1'b0; resume = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; s_reset = 1'b1;
    test_reset();
    test_branch();
    test_halt_resume();
    test_haltint_haltext();
    test_reset_mid_halt();
    test_small_wrap_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
